// File: rtl/tinyalu_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tinyalu_cmd_dispatcher
// Description : Command queue and sequencer sitting in front of the tinyALU.
//               Commands {a, b, op, tag} are accepted over a valid/ready
//               channel into a DEPTH-entry FIFO. One command at a time is
//               popped, issued to the ALU through its start/op/A/B handshake,
//               and its result is returned with the originating tag on a
//               valid/ready response channel. Invalid opcodes and an ALU
//               that never raises done produce an error response.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   DEPTH    : command FIFO depth (power of 2, >= 2)
//   TIMEOUT  : cycles alu_start may stay high without alu_done (>= 2)
// Ports
//   clk, reset_n               : clock, asynchronous active-low reset
//   i_cmd_valid / o_cmd_ready  : command handshake
//   i_cmd_a, i_cmd_b           : 8-bit operands
//   i_cmd_op                   : 3-bit opcode (0 nop, 1 add, 2 and, 3 xor,
//                                4 mul, 5..7 invalid)
//   i_cmd_tag                  : 4-bit opaque ID echoed on the response
//   o_rsp_valid / i_rsp_ready  : response handshake
//   o_rsp_result, o_rsp_tag    : 16-bit result and echoed tag
//   o_rsp_err                  : invalid opcode or ALU timeout
//   o_alu_a, o_alu_b, o_alu_op : ALU operands/opcode (held between commands)
//   o_alu_start / i_alu_done   : ALU handshake
//   i_alu_result               : ALU result, captured on done
//   o_count                    : FIFO occupancy
// ============================================================================
module tinyalu_cmd_dispatcher #(
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic                     clk,
   input  logic                     reset_n,
   // command channel
   input  logic                     i_cmd_valid,
   output logic                     o_cmd_ready,
   input  logic [7:0]               i_cmd_a,
   input  logic [7:0]               i_cmd_b,
   input  logic [2:0]               i_cmd_op,
   input  logic [3:0]               i_cmd_tag,
   // response channel
   output logic                     o_rsp_valid,
   input  logic                     i_rsp_ready,
   output logic [15:0]              o_rsp_result,
   output logic [3:0]               o_rsp_tag,
   output logic                     o_rsp_err,
   // ALU side
   output logic [7:0]               o_alu_a,
   output logic [7:0]               o_alu_b,
   output logic [2:0]               o_alu_op,
   output logic                     o_alu_start,
   input  logic                     i_alu_done,
   input  logic [15:0]              i_alu_result,
   // status
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_TW = $clog2(TIMEOUT + 1);

   localparam logic [c_AW:0]   c_FULL       = (c_AW + 1)'(DEPTH);
   localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(TIMEOUT - 1);
   localparam logic [2:0]      c_OP_NOP     = 3'd0;
   localparam logic [2:0]      c_OP_MAX     = 3'd4;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_NOP   = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] op;
      logic [3:0] tag;
   } entry_t;

   // -------------------------------------------------------------------------
   // Command FIFO
   // -------------------------------------------------------------------------
   entry_t          r_mem [DEPTH];
   logic [c_AW-1:0] r_wr_ptr;
   logic [c_AW-1:0] r_rd_ptr;
   logic [c_AW:0]   r_count;

   entry_t          w_wr_entry;
   entry_t          w_head;
   logic            w_push;
   logic            w_pop;

   // Ready is qualified with reset_n so it drops and rises combinationally
   // with the reset pin rather than waiting for a clock edge.
   assign o_cmd_ready = reset_n && (r_count < c_FULL);
   assign w_push      = i_cmd_valid && o_cmd_ready;

   assign w_wr_entry.a   = i_cmd_a;
   assign w_wr_entry.b   = i_cmd_b;
   assign w_wr_entry.op  = i_cmd_op;
   assign w_wr_entry.tag = i_cmd_tag;

   assign w_head = r_mem[r_rd_ptr];

   // Storage carries no reset: entries are only ever read when r_count says
   // they were written after the last reset.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_wr_entry;
      end
   end

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_count = r_count;

   // -------------------------------------------------------------------------
   // Sequencer
   // -------------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nxt;
   logic [c_TW-1:0] r_timer;
   logic [c_TW-1:0] w_timer_nxt;
   logic [7:0]      r_alu_a;
   logic [7:0]      w_alu_a_nxt;
   logic [7:0]      r_alu_b;
   logic [7:0]      w_alu_b_nxt;
   logic [2:0]      r_alu_op;
   logic [2:0]      w_alu_op_nxt;
   logic [15:0]     r_rsp_result;
   logic [15:0]     w_rsp_result_nxt;
   logic [3:0]      r_rsp_tag;
   logic [3:0]      w_rsp_tag_nxt;
   logic            r_rsp_err;
   logic            w_rsp_err_nxt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_timer      <= '0;
         r_alu_a      <= '0;
         r_alu_b      <= '0;
         r_alu_op     <= '0;
         r_rsp_result <= '0;
         r_rsp_tag    <= '0;
         r_rsp_err    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_timer      <= w_timer_nxt;
         r_alu_a      <= w_alu_a_nxt;
         r_alu_b      <= w_alu_b_nxt;
         r_alu_op     <= w_alu_op_nxt;
         r_rsp_result <= w_rsp_result_nxt;
         r_rsp_tag    <= w_rsp_tag_nxt;
         r_rsp_err    <= w_rsp_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_timer_nxt      = r_timer;
      w_alu_a_nxt      = r_alu_a;
      w_alu_b_nxt      = r_alu_b;
      w_alu_op_nxt     = r_alu_op;
      w_rsp_result_nxt = r_rsp_result;
      w_rsp_tag_nxt    = r_rsp_tag;
      w_rsp_err_nxt    = r_rsp_err;
      w_pop            = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (r_count != '0) begin
               w_pop         = 1'b1;
               w_rsp_tag_nxt = w_head.tag;
               if (w_head.op <= c_OP_MAX) begin
                  // no_op still pulses start for one cycle with its operands
                  w_alu_a_nxt  = w_head.a;
                  w_alu_b_nxt  = w_head.b;
                  w_alu_op_nxt = w_head.op;
                  w_timer_nxt  = '0;
                  w_state_nxt  = (w_head.op == c_OP_NOP) ? S_NOP : S_ISSUE;
               end else begin
                  // Malformed opcode: answer straight away, ALU untouched.
                  w_rsp_result_nxt = '0;
                  w_rsp_err_nxt    = 1'b1;
                  w_state_nxt      = S_RESP;
               end
            end
         end

         S_ISSUE: begin
            // done is tested first so it wins over a coincident timeout
            if (i_alu_done) begin
               w_rsp_result_nxt = i_alu_result;
               w_rsp_err_nxt    = 1'b0;
               w_state_nxt      = S_RESP;
            end else if (r_timer == c_TIMER_LAST) begin
               // TIMEOUT-th edge in ISSUE without done
               w_rsp_result_nxt = '0;
               w_rsp_err_nxt    = 1'b1;
               w_state_nxt      = S_RESP;
            end else begin
               w_timer_nxt = r_timer + 1'b1;
            end
         end

         S_NOP: begin
            w_rsp_result_nxt = '0;
            w_rsp_err_nxt    = 1'b0;
            w_state_nxt      = S_RESP;
         end

         S_RESP: begin
            if (i_rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Handshake outputs decode straight from the state register, so reset
   // clears them without needing a clock edge.
   assign o_alu_start  = (r_state == S_ISSUE) || (r_state == S_NOP);
   assign o_rsp_valid  = (r_state == S_RESP);
   assign o_alu_a      = r_alu_a;
   assign o_alu_b      = r_alu_b;
   assign o_alu_op     = r_alu_op;
   assign o_rsp_result = r_rsp_result;
   assign o_rsp_tag    = r_rsp_tag;
   assign o_rsp_err    = r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_tinyalu_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_tinyalu_cmd_dispatcher
// Description : Directed, table-driven bench for tinyalu_cmd_dispatcher with
//               a small behavioural ALU whose done latency is programmable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tinyalu_cmd_dispatcher;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_a = '0;
   logic [7:0]  cmd_b = '0;
   logic [2:0]  cmd_op = '0;
   logic [3:0]  cmd_tag = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_tag;
   logic        rsp_err;
   logic [7:0]  alu_a;
   logic [7:0]  alu_b;
   logic [2:0]  alu_op;
   logic        alu_start;
   logic        alu_done = 1'b0;
   logic [15:0] alu_result = '0;
   logic [$clog2(DEPTH):0] count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tinyalu_cmd_dispatcher #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_cmd_valid  (cmd_valid),
      .o_cmd_ready  (cmd_ready),
      .i_cmd_a      (cmd_a),
      .i_cmd_b      (cmd_b),
      .i_cmd_op     (cmd_op),
      .i_cmd_tag    (cmd_tag),
      .o_rsp_valid  (rsp_valid),
      .i_rsp_ready  (rsp_ready),
      .o_rsp_result (rsp_result),
      .o_rsp_tag    (rsp_tag),
      .o_rsp_err    (rsp_err),
      .o_alu_a      (alu_a),
      .o_alu_b      (alu_b),
      .o_alu_op     (alu_op),
      .o_alu_start  (alu_start),
      .i_alu_done   (alu_done),
      .i_alu_result (alu_result),
      .o_count      (count)
   );

   // ---------------------------------------------------------------- ALU model
   // alu_lat = number of cycles start is high before done is sampled; 0 = hang.
   int alu_lat = 1;
   int scnt = 0;

   function automatic logic [15:0] alu_calc(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b);
      case (op)
         3'd1:    return 16'(a) + 16'(b);
         3'd2:    return {8'h00, a & b};
         3'd3:    return {8'h00, a ^ b};
         3'd4:    return 16'(a) * 16'(b);
         default: return 16'h0000;
      endcase
   endfunction

   always @(posedge clk) scnt <= alu_start ? scnt + 1 : 0;

   always @(negedge clk) begin
      alu_done   = (alu_lat != 0) && alu_start && (scnt == alu_lat - 1);
      alu_result = alu_calc(alu_op, alu_a, alu_b);
   end

   // ---------------------------------------------------------------- helpers
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [3:0] tag);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag; cmd_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      checks++;
      if (ok) begin
         @(posedge clk);
         #1;
      end else begin
         errors++;
         $display("FAIL push_accept tag=%0d: cmd_ready stayed 0 for 200 cycles", tag);
      end
      cmd_valid = 1'b0;
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [2:0]  op;
      logic [3:0]  tag;
      int          lat;        // ALU model latency, 0 = hang
      logic [15:0] exp_res;
      logic        exp_err;
      int          exp_starts; // cycles alu_start is high
      int          exp_rlat;   // negedges after the push edge until rsp_valid
   } vec_t;

   // Waits for one response, counting alu_start cycles and checking operands.
   task automatic expect_rsp(input vec_t v, input bit chk_lat);
      int  starts;
      int  n;
      bit  seen;
      starts = 0;
      seen   = 1'b0;
      n      = 0;
      for (int i = 1; i <= 60; i++) begin
         @(negedge clk);
         n = i;
         if (chk_lat && i == 1) check("count_after_push", 32'(count), 32'd1);
         if (alu_start) begin
            starts++;
            check("alu_a", 32'(alu_a), 32'(v.a));
            check("alu_b", 32'(alu_b), 32'(v.b));
            check("alu_op", 32'(alu_op), 32'(v.op));
         end
         if (rsp_valid) begin
            seen = 1'b1;
            break;
         end
      end
      check("rsp_seen", 32'(seen), 32'd1);
      if (seen) begin
         check("rsp_result", 32'(rsp_result), 32'(v.exp_res));
         check("rsp_tag", 32'(rsp_tag), 32'(v.tag));
         check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
         check("start_cycles", 32'(starts), 32'(v.exp_starts));
         if (chk_lat) check("rsp_latency", 32'(n), 32'(v.exp_rlat));
         @(posedge clk);
         #1;
      end
   endtask

   vec_t vecs [11];

   // ---------------------------------------------------------------- main
   initial begin
      vecs[0]  = '{8'hFF, 8'hFF, 3'd1, 4'd3,  2, 16'h01FE, 1'b0,  2,  4};
      vecs[1]  = '{8'h0F, 8'hF0, 3'd2, 4'd1,  1, 16'h0000, 1'b0,  1,  3};
      vecs[2]  = '{8'hAA, 8'h0F, 3'd3, 4'd2,  3, 16'h00A5, 1'b0,  3,  5};
      vecs[3]  = '{8'hFF, 8'hFF, 3'd4, 4'd4,  4, 16'hFE01, 1'b0,  4,  6};
      vecs[4]  = '{8'h12, 8'h34, 3'd7, 4'd9,  0, 16'h0000, 1'b1,  0,  2};
      vecs[5]  = '{8'h55, 8'h66, 3'd0, 4'd10, 1, 16'h0000, 1'b0,  1,  3};
      vecs[6]  = '{8'h01, 8'h02, 3'd5, 4'd11, 0, 16'h0000, 1'b1,  0,  2};
      vecs[7]  = '{8'h0C, 8'h0D, 3'd1, 4'd15, 1, 16'h0019, 1'b0,  1,  3};
      vecs[8]  = '{8'h03, 8'h05, 3'd4, 4'd6,  0, 16'h0000, 1'b1, 15, 17};
      vecs[9]  = '{8'h03, 8'h05, 3'd4, 4'd7,  2, 16'h000F, 1'b0,  2,  4};
      vecs[10] = '{8'h07, 8'h01, 3'd6, 4'd12, 0, 16'h0000, 1'b1,  0,  2};

      // Reset: held low for 3 cycles
      #1 reset_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      check("rst_rsp", 32'({rsp_valid, rsp_result, rsp_tag, rsp_err}), 32'd0);
      check("rst_alu", 32'({alu_start, alu_a, alu_b, alu_op}), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("rel_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rel_count", 32'(count), 32'd0);
      check("rel_rsp_valid", 32'(rsp_valid), 32'd0);

      // Table: one command at a time, response consumed immediately
      rsp_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         alu_lat = vecs[k].lat;
         push(vecs[k].a, vecs[k].b, vecs[k].op, vecs[k].tag);
         expect_rsp(vecs[k], 1'b1);
      end

      // Timeout followed by an already-queued command
      alu_lat = 0;
      push(8'h09, 8'h02, 3'd4, 4'd13);
      push(8'h21, 8'h13, 3'd3, 4'd14);
      expect_rsp('{8'h09, 8'h02, 3'd4, 4'd13, 0, 16'h0000, 1'b1, 15, 0}, 1'b0);
      alu_lat = 2;
      expect_rsp('{8'h21, 8'h13, 3'd3, 4'd14, 2, 16'h0032, 1'b0, 2, 0}, 1'b0);

      // Backpressure: response stalled, FIFO fills, tag 5 waits
      alu_lat   = 1;
      rsp_ready = 1'b0;
      fork
         begin
            for (int k = 0; k < 6; k++) push(8'(8'h10 + k), 8'h01, 3'd1, 4'(k));
         end
         begin
            repeat (12) @(negedge clk);
            check("bp_count_full", 32'(count), 32'd4);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_tag0", 32'(rsp_tag), 32'd0);
            rsp_ready = 1'b1;
            for (int k = 0; k < 6; k++) begin
               bit got;
               got = 1'b0;
               for (int i = 0; i < 40; i++) begin
                  if (rsp_valid) begin
                     got = 1'b1;
                     break;
                  end
                  @(negedge clk);
               end
               check("bp_rsp_seen", 32'(got), 32'd1);
               if (got) begin
                  check("bp_rsp_tag", 32'(rsp_tag), 32'(k));
                  check("bp_rsp_result", 32'(rsp_result), 32'(16'h0011 + 16'(k)));
                  check("bp_rsp_err", 32'(rsp_err), 32'd0);
                  @(posedge clk);
                  #1;
               end
            end
         end
      join
      @(negedge clk);
      check("bp_count_empty", 32'(count), 32'd0);

      // Reset mid-ISSUE with two commands queued
      alu_lat = 0;
      push(8'h44, 8'h55, 3'd1, 4'd1);
      push(8'h01, 8'h01, 3'd2, 4'd2);
      push(8'h02, 8'h02, 3'd3, 4'd3);
      @(negedge clk);
      check("mid_start_before", 32'(alu_start), 32'd1);
      check("mid_count_before", 32'(count), 32'd2);
      #2 reset_n = 1'b0;
      #1;
      check("mid_start_async", 32'(alu_start), 32'd0);
      check("mid_count_async", 32'(count), 32'd0);
      check("mid_alu_a_async", 32'(alu_a), 32'd0);
      check("mid_cmd_ready_async", 32'(cmd_ready), 32'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      alu_lat = 1;
      begin
         bit activity;
         activity = 1'b0;
         repeat (30) begin
            @(negedge clk);
            if (rsp_valid || alu_start) activity = 1'b1;
         end
         check("mid_no_activity", 32'(activity), 32'd0);
         check("mid_count_after", 32'(count), 32'd0);
         check("mid_cmd_ready_after", 32'(cmd_ready), 32'd1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
